// File: rtl/any1_issue_scheduler.sv
// any1_issue_scheduler: multi-lane ROB wakeup/select with per-lane valid/ack
// output registers, mem/flow-control ordering, pend tracking and starvation forcing.
module any1_issue_scheduler #(
    parameter int ROB_ENTRIES = 64,
    parameter int RID_W       = 6,
    parameter int LANES       = 2,
    parameter int STARVE_MAX  = 15
) (
    input  logic                     rst_i,
    input  logic                     clk_i,
    input  logic                     flush_i,
    input  logic [RID_W-1:0]         que_i,
    input  logic                     mode_i,
    input  logic [ROB_ENTRIES-1:0]   rob_v_i,
    input  logic [ROB_ENTRIES-1:0]   rob_dec_i,
    input  logic [ROB_ENTRIES-1:0]   rob_cmt_i,
    input  logic [ROB_ENTRIES-1:0]   rob_out_i,
    input  logic [ROB_ENTRIES-1:0]   rob_argv_i,
    input  logic [ROB_ENTRIES-1:0]   rob_mem_i,
    input  logic [ROB_ENTRIES-1:0]   rob_fc_i,
    input  logic [ROB_ENTRIES-1:0]   rob_br_i,
    input  logic [LANES-1:0]         iss_ack_i,
    output logic [LANES-1:0]         iss_v_o,
    output logic [LANES*RID_W-1:0]   iss_rid_o,
    output logic [ROB_ENTRIES-1:0]   wakeup_o,
    output logic                     starve_o
);

    localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 4) ? $clog2(STARVE_MAX + 1) : 4;

    logic [LANES-1:0]             iss_v_q;
    logic [LANES-1:0][RID_W-1:0]  iss_rid_q;
    logic [ROB_ENTRIES-1:0]       pend_q;
    logic [CNT_W-1:0]             starve_cnt_q;
    logic                         starve_q;

    // Vectors are rotated by que_i so that bit index equals age (bit 0 = oldest).
    function automatic logic [ROB_ENTRIES-1:0] to_age(input logic [ROB_ENTRIES-1:0] vec,
                                                      input logic [RID_W-1:0] q);
        logic [ROB_ENTRIES-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < ROB_ENTRIES; i++)
            r[i] = vec[RID_W'(i) + q];
        return r;
    endfunction

    function automatic logic [ROB_ENTRIES-1:0] from_age(input logic [ROB_ENTRIES-1:0] vec,
                                                        input logic [RID_W-1:0] q);
        logic [ROB_ENTRIES-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < ROB_ENTRIES; i++)
            r[RID_W'(i) + q] = vec[i];
        return r;
    endfunction

    function automatic logic [RID_W-1:0] first_set(input logic [ROB_ENTRIES-1:0] vec);
        logic [RID_W-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < ROB_ENTRIES; i++) begin
            if (vec[i] && !found) begin
                r     = RID_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    logic [ROB_ENTRIES-1:0] held, set_pend, base, inflight, elig;
    logic [ROB_ENTRIES-1:0] base_age, fc_age, mem_age, memop_age, br_age, elig_age;
    logic                   older_fc, older_mem;

    always_comb begin
        held     = '0;
        set_pend = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (iss_v_q[l]) held[iss_rid_q[l]] = 1'b1;
            if (iss_v_q[l] && iss_ack_i[l]) set_pend[iss_rid_q[l]] = 1'b1;
        end
    end

    assign base      = rob_v_i & rob_dec_i & ~rob_cmt_i & ~rob_out_i & rob_argv_i & ~pend_q & ~held;
    assign inflight  = rob_v_i & ~rob_cmt_i & ~rob_out_i;
    assign base_age  = to_age(base, que_i);
    assign fc_age    = to_age(inflight & rob_fc_i, que_i);
    assign mem_age   = to_age(inflight & rob_mem_i, que_i);
    assign memop_age = to_age(rob_mem_i, que_i);
    assign br_age    = to_age(rob_br_i, que_i);

    // Held/in-flight mem ops count as older blockers, so at most one mem op is ever eligible.
    always_comb begin
        elig_age  = '0;
        older_fc  = 1'b0;
        older_mem = 1'b0;
        for (int unsigned i = 0; i < ROB_ENTRIES; i++) begin
            elig_age[i] = base_age[i] & ~older_fc & ~(memop_age[i] & older_mem);
            older_fc    = older_fc | fc_age[i];
            older_mem   = older_mem | mem_age[i];
        end
    end

    assign elig     = from_age(elig_age, que_i);
    assign wakeup_o = rst_i ? '0 : elig;

    logic [LANES-1:0]            lane_free, pick_v;
    logic [LANES-1:0][RID_W-1:0] pick_d;
    logic [ROB_ENTRIES-1:0]      pool;
    logic [RID_W-1:0]            sel_d, oldest_d;
    logic                        first_free, force_sel, oldest_sel, oldest_any;

    assign lane_free  = ~iss_v_q | iss_ack_i;
    assign oldest_any = |elig_age;
    assign oldest_d   = first_set(elig_age);

    always_comb begin
        pool       = elig_age;
        pick_v     = '0;
        pick_d     = '0;
        sel_d      = '0;
        first_free = 1'b1;
        force_sel  = 1'b0;
        oldest_sel = 1'b0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (lane_free[l] && !flush_i) begin
                if (|pool) begin
                    if (first_free && starve_cnt_q == CNT_W'(STARVE_MAX)) begin
                        sel_d     = first_set(pool);
                        force_sel = 1'b1;
                    end else if (first_free && mode_i && |(pool & br_age)) begin
                        sel_d = first_set(pool & br_age);
                    end else begin
                        sel_d = first_set(pool);
                    end
                    pick_v[l]   = 1'b1;
                    pick_d[l]   = sel_d;
                    pool[sel_d] = 1'b0;
                    if (sel_d == oldest_d) oldest_sel = 1'b1;
                end
                first_free = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iss_v_q      <= '0;
            iss_rid_q    <= '0;
            pend_q       <= '0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else if (flush_i) begin
            iss_v_q      <= '0;
            pend_q       <= '0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            pend_q   <= (pend_q | set_pend) & rob_v_i & ~rob_out_i;
            starve_q <= force_sel;
            if (force_sel || !oldest_any || oldest_sel)
                starve_cnt_q <= '0;
            else if (starve_cnt_q != CNT_W'(STARVE_MAX))
                starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            for (int unsigned l = 0; l < LANES; l++) begin
                if (lane_free[l]) begin
                    iss_v_q[l] <= pick_v[l];
                    if (pick_v[l]) iss_rid_q[l] <= pick_d[l] + que_i;
                end else if (!rob_v_i[iss_rid_q[l]] || rob_cmt_i[iss_rid_q[l]]) begin
                    iss_v_q[l] <= 1'b0;
                end
            end
        end
    end

    assign iss_v_o   = iss_v_q;
    assign iss_rid_o = iss_rid_q;
    assign starve_o  = starve_q;

endmodule

// File: tb/tb_any1_issue_scheduler.sv
// Scoreboard bench for any1_issue_scheduler: a 2-lane instance for ordering,
// handshake and flush/reset, plus a 1-lane STARVE_MAX=3 instance for starvation.
module tb_any1_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst, flush, mode;
    logic [5:0]  que;
    logic [63:0] rob_v, rob_dec, rob_cmt, rob_out, rob_argv, rob_mem, rob_fc, rob_br;
    logic [1:0]  ack;
    logic        ack1;
    logic [1:0]  iss_v;
    logic [11:0] iss_rid;
    logic [63:0] wakeup, wakeup1;
    logic        starve, starve1;
    logic [0:0]  iss_v1;
    logic [5:0]  iss_rid1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    any1_issue_scheduler #(.ROB_ENTRIES(64), .RID_W(6), .LANES(2), .STARVE_MAX(15)) u_dut (
        .rst_i(rst), .clk_i(clk), .flush_i(flush), .que_i(que), .mode_i(mode),
        .rob_v_i(rob_v), .rob_dec_i(rob_dec), .rob_cmt_i(rob_cmt), .rob_out_i(rob_out),
        .rob_argv_i(rob_argv), .rob_mem_i(rob_mem), .rob_fc_i(rob_fc), .rob_br_i(rob_br),
        .iss_ack_i(ack), .iss_v_o(iss_v), .iss_rid_o(iss_rid), .wakeup_o(wakeup), .starve_o(starve)
    );

    any1_issue_scheduler #(.ROB_ENTRIES(64), .RID_W(6), .LANES(1), .STARVE_MAX(3)) u_dut1 (
        .rst_i(rst), .clk_i(clk), .flush_i(flush), .que_i(que), .mode_i(mode),
        .rob_v_i(rob_v), .rob_dec_i(rob_dec), .rob_cmt_i(rob_cmt), .rob_out_i(rob_out),
        .rob_argv_i(rob_argv), .rob_mem_i(rob_mem), .rob_fc_i(rob_fc), .rob_br_i(rob_br),
        .iss_ack_i(ack1), .iss_v_o(iss_v1), .iss_rid_o(iss_rid1), .wakeup_o(wakeup1), .starve_o(starve1)
    );

    // Codes: 0/1 lane v, 2/3 lane rid, 4 starve (2-lane); 5 v, 6 rid, 7 starve (1-lane).
    typedef struct {
        string      tag;
        int         code;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] observe(input int code);
        case (code)
            0: return {7'd0, iss_v[0]};
            1: return {7'd0, iss_v[1]};
            2: return {2'd0, iss_rid[5:0]};
            3: return {2'd0, iss_rid[11:6]};
            4: return {7'd0, starve};
            5: return {7'd0, iss_v1[0]};
            6: return {2'd0, iss_rid1};
            default: return {7'd0, starve1};
        endcase
    endfunction

    task automatic exp_issue(input string tag, input int lane, input logic [5:0] rid);
        sb.push_back('{tag: {tag, "_v"}, code: lane, val: 8'd1});
        sb.push_back('{tag: {tag, "_rid"}, code: 2 + lane, val: {2'd0, rid}});
    endtask

    task automatic exp_idle(input string tag, input int lane);
        sb.push_back('{tag: {tag, "_v"}, code: lane, val: 8'd0});
    endtask

    task automatic exp1_issue(input string tag, input logic [5:0] rid, input logic stv);
        sb.push_back('{tag: {tag, "_v"}, code: 5, val: 8'd1});
        sb.push_back('{tag: {tag, "_rid"}, code: 6, val: {2'd0, rid}});
        sb.push_back('{tag: {tag, "_starve"}, code: 7, val: {7'd0, stv}});
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, 64'(observe(e.code)), 64'(e.val));
        end
    endtask

    task automatic clear_rob();
        rob_v = '0; rob_dec = '0; rob_cmt = '0; rob_out = '0;
        rob_argv = '0; rob_mem = '0; rob_fc = '0; rob_br = '0;
    endtask

    task automatic ready(input int n);
        rob_v[n] = 1'b1; rob_dec[n] = 1'b1; rob_argv[n] = 1'b1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; flush = 1'b0; ack = '0; ack1 = 1'b0; mode = 1'b0; que = '0;
        clear_rob();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] bits(input int a, input int b, input int c);
        logic [63:0] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        return m;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset values and wakeup gating during reset
        reset_dut();
        rst = 1'b1;
        ready(7);
        #1;
        check("wakeup_in_rst", wakeup, '0);
        exp_idle("rst_l0", 0);
        exp_idle("rst_l1", 1);
        sb.push_back('{tag: "rst_rid", code: 2, val: 8'd0});
        sb.push_back('{tag: "rst_starve", code: 4, val: 8'd0});
        tick();
        rst = 1'b0;

        // Oldest-first across wrap
        reset_dut();
        que = 6'd62;
        ready(1); ready(63); ready(62);
        #1;
        check("wrap_wakeup", wakeup, bits(1, 62, 63));
        exp_issue("wrap_l0", 0, 6'd62);
        exp_issue("wrap_l1", 1, 6'd63);
        tick();
        check("wrap_wakeup_held", wakeup, bits(1, -1, -1));
        ack = 2'b11;
        exp_issue("wrap_l0_next", 0, 6'd1);
        exp_idle("wrap_l1_next", 1);
        tick();
        ack = 2'b00;
        #1;
        check("wrap_pend_wakeup", wakeup, '0);

        // Mem ordering
        reset_dut();
        que = 6'd5;
        ready(5); ready(6); rob_mem[5] = 1'b1; rob_mem[6] = 1'b1;
        #1;
        check("mem_wakeup", wakeup, bits(5, -1, -1));
        exp_issue("mem_l0", 0, 6'd5);
        exp_idle("mem_l1", 1);
        tick();
        check("mem_wakeup_held", wakeup, '0);
        ack = 2'b01;
        exp_idle("mem_l0_ack", 0);
        tick();
        ack = 2'b00;
        check("mem_wakeup_pend", wakeup, '0);
        rob_out[5] = 1'b1;
        #1;
        check("mem_wakeup_out", wakeup, bits(6, -1, -1));
        exp_issue("mem_l0_6", 0, 6'd6);
        tick();

        // Branch-first vs oldest-first
        reset_dut();
        mode = 1'b1;
        ready(2); ready(9); rob_br[9] = 1'b1;
        exp_issue("brf_l0", 0, 6'd9);
        exp_issue("brf_l1", 1, 6'd2);
        tick();
        reset_dut();
        ready(2); ready(9); rob_br[9] = 1'b1;
        exp_issue("old_l0", 0, 6'd2);
        exp_issue("old_l1", 1, 6'd9);
        tick();

        // Handshake hold, pend and invalidate-while-held
        reset_dut();
        ready(4);
        exp_issue("hs_l0", 0, 6'd4);
        exp_idle("hs_l1", 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_issue("hs_hold", 0, 6'd4);
            tick();
        end
        ack = 2'b01;
        exp_idle("hs_ack", 0);
        tick();
        ack = 2'b00;
        for (int i = 0; i < 2; i++) begin
            check("hs_pend_wakeup", wakeup, '0);
            exp_idle("hs_no_reissue", 0);
            tick();
        end
        ready(3);
        exp_issue("hs_l0_3", 0, 6'd3);
        tick();
        rob_v[3] = 1'b0;
        exp_idle("hs_invalidate", 0);
        tick();

        // Starvation on the single-lane instance
        reset_dut();
        mode = 1'b1;
        ack = 2'b11;
        ack1 = 1'b1;
        ready(0);
        ready(10); rob_br[10] = 1'b1;
        exp1_issue("stv_br10", 6'd10, 1'b0);
        tick();
        for (int k = 11; k <= 13; k++) begin
            rob_v[k-1] = 1'b0; rob_br[k-1] = 1'b0;
            ready(k); rob_br[k] = 1'b1;
            if (k < 13) exp1_issue("stv_br", 6'(k), 1'b0);
            else        exp1_issue("stv_force", 6'd0, 1'b1);
            tick();
        end
        exp1_issue("stv_after", 6'd13, 1'b0);
        tick();

        // Flush with both lanes valid and ack high
        reset_dut();
        ready(1); ready(2);
        exp_issue("fl_l0", 0, 6'd1);
        exp_issue("fl_l1", 1, 6'd2);
        tick();
        flush = 1'b1;
        ack = 2'b11;
        exp_idle("fl_l0_clr", 0);
        exp_idle("fl_l1_clr", 1);
        sb.push_back('{tag: "fl_starve", code: 4, val: 8'd0});
        tick();
        flush = 1'b0;
        ack = 2'b00;
        check("fl_wakeup", wakeup, bits(1, 2, -1));
        exp_issue("fl_l0_re", 0, 6'd1);
        exp_issue("fl_l1_re", 1, 6'd2);
        tick();

        // Reset mid-handshake
        rst = 1'b1;
        ack = 2'b11;
        #1;
        check("rh_wakeup_rst", wakeup, '0);
        exp_idle("rh_l0", 0);
        exp_idle("rh_l1", 1);
        sb.push_back('{tag: "rh_rid", code: 2, val: 8'd0});
        tick();
        rst = 1'b0;
        ack = 2'b00;
        #1;
        check("rh_wakeup", wakeup, bits(1, 2, -1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
